// File: rtl/cache_flush_walker_if.sv
// rtl/cache_flush_walker_if.sv - flush walker handshake, tag-store command and write-back bus
interface cache_flush_walker_if #(
  parameter int LSB          = 6,
  parameter int WSB          = 1,
  parameter int TAG_SEL_BITS = 20
);
  logic                    grant;
  logic                    start_valid;
  logic                    start_ready;
  logic                    done_valid;
  logic                    done_ready;
  logic                    busy;
  logic                    tag_init;
  logic                    tag_flush;
  logic [LSB-1:0]          tag_line_idx;
  logic [LSB-1:0]          tag_line_idx_n;
  logic [WSB-1:0]          tag_evict_way;
  logic                    tag_evict_dirty;
  logic [TAG_SEL_BITS-1:0] tag_evict_tag;
  logic                    wb_valid;
  logic                    wb_ready;
  logic [LSB-1:0]          wb_line_idx;
  logic [TAG_SEL_BITS-1:0] wb_tag;

  modport master (
    input  grant, start_valid, done_ready, tag_evict_dirty, tag_evict_tag, wb_ready,
    output start_ready, done_valid, busy, tag_init, tag_flush, tag_line_idx,
           tag_line_idx_n, tag_evict_way, wb_valid, wb_line_idx, wb_tag
  );

  modport slave (
    output grant, start_valid, done_ready, tag_evict_dirty, tag_evict_tag, wb_ready,
    input  start_ready, done_valid, busy, tag_init, tag_flush, tag_line_idx,
           tag_line_idx_n, tag_evict_way, wb_valid, wb_line_idx, wb_tag
  );
endinterface

// File: rtl/cache_flush_walker.sv
// rtl/cache_flush_walker.sv - walks a bank's tag store for init after reset and for flush requests
module cache_flush_walker #(
  parameter int CACHE_SIZE   = 1024,
  parameter int LINE_SIZE    = 16,
  parameter int NUM_BANKS    = 1,
  parameter int NUM_WAYS     = 1,
  parameter int WRITEBACK    = 0,
  parameter int TAG_SEL_BITS = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_flush_walker_if.master bus
);
  localparam int LINES = CACHE_SIZE / (LINE_SIZE * NUM_BANKS);
  localparam int LSB   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int WSB   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES - 1);
  localparam logic [WSB-1:0] LAST_WAY  = WSB'(NUM_WAYS - 1);
  localparam bit WB_EN = (WRITEBACK != 0);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_FLUSH, S_WB, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LSB-1:0]          line_q, line_d;
  logic [WSB-1:0]          way_q, way_d;
  logic [LSB-1:0]          wb_line_q, wb_line_d;
  logic [TAG_SEL_BITS-1:0] wb_tag_q, wb_tag_d;
  logic                    busy_q, busy_d;
  logic                    start_ready_q, start_ready_d;
  logic                    done_valid_q, done_valid_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    advance;

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    way_d     = way_q;
    wb_line_d = wb_line_q;
    wb_tag_d  = wb_tag_q;
    advance   = 1'b0;

    case (state_q)
      S_INIT: begin
        if (bus.grant) begin
          if (line_q == LAST_LINE) begin
            state_d = S_IDLE;
            line_d  = '0;
          end else begin
            line_d = line_q + LSB'(1);
          end
        end
      end
      S_IDLE: begin
        if (bus.start_valid && start_ready_q) begin
          line_d  = '0;
          way_d   = '0;
          state_d = WB_EN ? S_READ : S_FLUSH;
        end
      end
      S_READ: begin
        if (bus.grant) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (bus.grant) begin
          if (WB_EN) begin
            wb_line_d = line_q;
            wb_tag_d  = bus.tag_evict_tag;
            if (bus.tag_evict_dirty) state_d = S_WB;
            else                     advance = 1'b1;
          end else if (line_q == LAST_LINE) begin
            state_d = S_DONE;
          end else begin
            line_d = line_q + LSB'(1);
          end
        end else if (WB_EN) begin
          // The read issued in READ may be stale once the bank owned the store; redo it.
          state_d = S_READ;
        end
      end
      S_WB: begin
        if (bus.wb_ready) advance = 1'b1;
      end
      S_DONE: begin
        if (bus.done_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    if (advance) begin
      if (way_q == LAST_WAY) begin
        if (line_q == LAST_LINE) begin
          state_d = S_DONE;
        end else begin
          way_d   = '0;
          line_d  = line_q + LSB'(1);
          state_d = S_READ;
        end
      end else begin
        way_d   = way_q + WSB'(1);
        state_d = S_READ;
      end
    end

    busy_d        = (state_d != S_IDLE);
    start_ready_d = (state_d == S_IDLE);
    done_valid_d  = (state_d == S_DONE);
    wb_valid_d    = (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_INIT;
      line_q        <= '0;
      way_q         <= '0;
      wb_line_q     <= '0;
      wb_tag_q      <= '0;
      busy_q        <= 1'b1;
      start_ready_q <= 1'b0;
      done_valid_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      way_q         <= way_d;
      wb_line_q     <= wb_line_d;
      wb_tag_q      <= wb_tag_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
      done_valid_q  <= done_valid_d;
      wb_valid_q    <= wb_valid_d;
    end
  end

  // Commands follow grant within the cycle; the bank owns the store whenever grant is low.
  assign bus.tag_init       = reset && bus.grant && (state_q == S_INIT);
  assign bus.tag_flush      = reset && bus.grant && (state_q == S_FLUSH);
  assign bus.tag_line_idx   = line_q;
  assign bus.tag_line_idx_n = line_q;
  assign bus.tag_evict_way  = way_q;
  assign bus.start_ready    = start_ready_q;
  assign bus.done_valid     = done_valid_q;
  assign bus.busy           = busy_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_line_idx    = wb_line_q;
  assign bus.wb_tag         = wb_tag_q;
endmodule

// File: tb/tb_cache_flush_walker.sv
// tb/tb_cache_flush_walker.sv - scoreboard bench for cache_flush_walker in write-through and write-back builds
module tb_cache_flush_walker;
  localparam int LSB = 6;
  localparam int WSB = 1;
  localparam int TW  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_wt, rst_wb;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   c_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  cache_flush_walker_if #(.LSB(LSB), .WSB(WSB), .TAG_SEL_BITS(TW)) wt_if ();
  cache_flush_walker_if #(.LSB(LSB), .WSB(WSB), .TAG_SEL_BITS(TW)) wb_if ();

  cache_flush_walker #(.CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(1),
                       .WRITEBACK(0), .TAG_SEL_BITS(TW))
    u_wt (.clk(clk), .reset(rst_wt), .bus(wt_if));

  cache_flush_walker #(.CACHE_SIZE(1024), .LINE_SIZE(16), .NUM_BANKS(1), .NUM_WAYS(2),
                       .WRITEBACK(1), .TAG_SEL_BITS(TW))
    u_wb (.clk(clk), .reset(rst_wb), .bus(wb_if));

  logic [5:0]  q_init_wt[$];
  logic [5:0]  q_init_wb[$];
  logic [5:0]  q_fl_wt[$];
  logic [6:0]  q_fl_wb[$];
  logic [25:0] q_wb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] tag_of(input logic [5:0] l, input logic w);
    if (l == 6'd5 && w) return 20'h3A;
    return 20'h100 + TW'({l, w});
  endfunction

  // Tag store model: only line 5 way 1 is dirty; read data lands one cycle after the address.
  always @(posedge clk) begin
    wb_if.tag_evict_dirty <= (wb_if.tag_line_idx_n == 6'd5) && (wb_if.tag_evict_way == 1'b1);
    wb_if.tag_evict_tag   <= tag_of(wb_if.tag_line_idx_n, wb_if.tag_evict_way);
  end

  always @(negedge clk) begin
    logic [5:0] e;
    check("wt_cmd_excl", wt_if.tag_init & wt_if.tag_flush, 0);
    check("wt_no_wb", wt_if.wb_valid, 0);
    if (wt_if.tag_init) begin
      if (q_init_wt.size() == 0) check("wt_init_extra", wt_if.tag_init, 0);
      else begin
        e = q_init_wt.pop_front();
        check("wt_init_line", wt_if.tag_line_idx, e);
        check("wt_init_idx_n", wt_if.tag_line_idx_n, e);
      end
    end
    if (wt_if.tag_flush) begin
      if (q_fl_wt.size() == 0) check("wt_flush_extra", wt_if.tag_flush, 0);
      else begin
        e = q_fl_wt.pop_front();
        check("wt_flush_line", wt_if.tag_line_idx, e);
        check("wt_flush_way", wt_if.tag_evict_way, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0]  e;
    logic [6:0]  ef;
    logic [25:0] ed;
    check("wb_cmd_excl", wb_if.tag_init & wb_if.tag_flush, 0);
    if (wb_if.tag_init) begin
      if (q_init_wb.size() == 0) check("wb_init_extra", wb_if.tag_init, 0);
      else begin
        e = q_init_wb.pop_front();
        check("wb_init_line", wb_if.tag_line_idx, e);
      end
    end
    if (wb_if.tag_flush) begin
      if (q_fl_wb.size() == 0) check("wb_flush_extra", wb_if.tag_flush, 0);
      else begin
        ef = q_fl_wb.pop_front();
        check("wb_flush_line", wb_if.tag_line_idx, ef[6:1]);
        check("wb_flush_idx_n", wb_if.tag_line_idx_n, ef[6:1]);
        check("wb_flush_way", wb_if.tag_evict_way, ef[0]);
      end
    end
    if (wb_if.wb_valid && wb_if.wb_ready) begin
      if (q_wb.size() == 0) check("wb_desc_extra", wb_if.wb_valid, 0);
      else begin
        ed = q_wb.pop_front();
        check("wb_desc_line", wb_if.wb_line_idx, ed[25:20]);
        check("wb_desc_tag", wb_if.wb_tag, ed[19:0]);
      end
    end
  end

  task automatic push_wb_walk();
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 2; w++) q_fl_wb.push_back({6'(l), 1'(w)});
    q_wb.push_back({6'd5, 20'h3A});
  endtask

  task automatic start_flush(input bit sel);
    @(posedge clk); #1;
    if (sel) wb_if.start_valid = 1'b1; else wt_if.start_valid = 1'b1;
    @(negedge clk);
    check(sel ? "wb_start_ready" : "wt_start_ready",
          sel ? wb_if.start_ready : wt_if.start_ready, 1);
    c_acc = cyc;
    @(posedge clk); #1;
    wb_if.start_valid = 1'b0;
    wt_if.start_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int exp_n, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (sel ? wb_if.done_valid : wt_if.done_valid) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_time"}, cyc - c_acc - 1, exp_n);
      @(posedge clk); @(negedge clk);
      check({tag, "_done_held"}, sel ? wb_if.done_valid : wt_if.done_valid, 1);
      @(posedge clk); #1;
      if (sel) wb_if.done_ready = 1'b1; else wt_if.done_ready = 1'b1;
      @(posedge clk); #1;
      wb_if.done_ready = 1'b0;
      wt_if.done_ready = 1'b0;
      @(negedge clk);
      check({tag, "_idle_ready"}, sel ? wb_if.start_ready : wt_if.start_ready, 1);
      check({tag, "_idle_busy"}, sel ? wb_if.busy : wt_if.busy, 0);
      check({tag, "_done_drop"}, sel ? wb_if.done_valid : wt_if.done_valid, 0);
    end
  endtask

  task automatic wait_wb_flush(input logic [5:0] l, input logic w, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (wb_if.tag_flush && wb_if.tag_line_idx == l && wb_if.tag_evict_way == w) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    bit seen;
    rst_wt = 1'b0; rst_wb = 1'b0;
    wt_if.grant = 1'b1; wt_if.start_valid = 1'b0; wt_if.done_ready = 1'b0; wt_if.wb_ready = 1'b1;
    wt_if.tag_evict_dirty = 1'b0; wt_if.tag_evict_tag = '0;
    wb_if.grant = 1'b1; wb_if.start_valid = 1'b0; wb_if.done_ready = 1'b0; wb_if.wb_ready = 1'b1;
    for (int l = 0; l < 64; l++) begin
      q_init_wt.push_back(6'(l));
      q_init_wb.push_back(6'(l));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wt_busy", wt_if.busy, 1);
    check("rst_wt_start_ready", wt_if.start_ready, 0);
    check("rst_wt_tag_init", wt_if.tag_init, 0);
    check("rst_wb_busy", wb_if.busy, 1);
    check("rst_wb_done", wb_if.done_valid, 0);
    check("rst_wb_wb_valid", wb_if.wb_valid, 0);
    check("rst_wb_wb_tag", wb_if.wb_tag, 0);
    @(posedge clk); #1;
    rst_wt = 1'b1; rst_wb = 1'b1;
    repeat (63) @(posedge clk);
    @(negedge clk);
    check("init64_wt_busy", wt_if.busy, 1);
    check("init64_wb_start_ready", wb_if.start_ready, 0);
    @(posedge clk); @(negedge clk);
    check("init65_wt_busy", wt_if.busy, 0);
    check("init65_wt_start_ready", wt_if.start_ready, 1);
    check("init65_wb_start_ready", wb_if.start_ready, 1);
    check("init_wt_all", q_init_wt.size(), 0);
    check("init_wb_all", q_init_wb.size(), 0);

    for (int l = 0; l < 64; l++) q_fl_wt.push_back(6'(l));
    start_flush(1'b0);
    wait_done(1'b0, 64, "wt");
    check("wt_flush_all", q_fl_wt.size(), 0);

    push_wb_walk();
    start_flush(1'b1);
    wait_done(1'b1, 257, "wb");
    check("wb_flush_all", q_fl_wb.size(), 0);
    check("wb_desc_all", q_wb.size(), 0);

    push_wb_walk();
    wb_if.wb_ready = 1'b0;
    start_flush(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (wb_if.wb_valid) seen = 1'b1;
    end
    check("stall_wb_seen", seen, 1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_wb_valid", wb_if.wb_valid, 1);
      check("stall_wb_line", wb_if.wb_line_idx, 5);
      check("stall_wb_tag", wb_if.wb_tag, 20'h3A);
      check("stall_no_flush", wb_if.tag_flush, 0);
      if (k == 9) begin
        @(posedge clk); #1;
        wb_if.wb_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("stall_resume_line", wb_if.tag_line_idx_n, 6);
    check("stall_resume_way", wb_if.tag_evict_way, 0);
    check("stall_wb_drop", wb_if.wb_valid, 0);
    wait_done(1'b1, 267, "stall");
    check("stall_flush_all", q_fl_wb.size(), 0);
    check("stall_desc_all", q_wb.size(), 0);

    push_wb_walk();
    start_flush(1'b1);
    wait_wb_flush(6'd6, 1'b1, "gd_seen");
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_if.grant = 1'b0;
    @(negedge clk);
    check("gd_no_flush", wb_if.tag_flush, 0);
    check("gd_hold_line", wb_if.tag_line_idx, 7);
    @(posedge clk); #1;
    wb_if.grant = 1'b1;
    @(negedge clk);
    check("gd_reread_no_flush", wb_if.tag_flush, 0);
    check("gd_reread_line", wb_if.tag_line_idx_n, 7);
    check("gd_reread_way", wb_if.tag_evict_way, 0);
    wait_done(1'b1, 259, "gd");
    check("gd_flush_all", q_fl_wb.size(), 0);

    for (int l = 0; l < 64; l++) q_fl_wt.push_back(6'(l));
    start_flush(1'b0);
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (wt_if.tag_flush && wt_if.tag_line_idx == 6'd30) seen = 1'b1;
    end
    check("mr_seen", seen, 1);
    @(posedge clk); #1;
    rst_wt = 1'b0;
    @(negedge clk);
    check("mr_no_flush", wt_if.tag_flush, 0);
    check("mr_done", wt_if.done_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_busy", wt_if.busy, 1);
    check("mr_start_ready", wt_if.start_ready, 0);
    check("mr_done2", wt_if.done_valid, 0);
    check("mr_tag_init", wt_if.tag_init, 0);
    check("mr_line", wt_if.tag_line_idx, 0);
    q_fl_wt.delete();
    for (int l = 0; l < 64; l++) q_init_wt.push_back(6'(l));
    @(posedge clk); #1;
    rst_wt = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    check("mr_reinit_ready", wt_if.start_ready, 1);
    check("mr_reinit_done", wt_if.done_valid, 0);
    check("mr_reinit_all", q_init_wt.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
